// File: rtl/systolic_feeder.sv
// Front end of the 4x4 weight-stationary systolic array. It loads one weight matrix
// column by column, then feeds pixel vectors into the array in diagonal skew and flushes with zeros.
module systolic_feeder #(
    parameter int BIT_WIDTH    = 16,
    parameter int DEPTH        = 4,
    parameter int PIX_WIDTH    = 8,
    parameter int DRAIN_CYCLES = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [BIT_WIDTH*DEPTH-1:0]     wt_in,
    input  logic                           wt_valid,
    output logic                           wt_ready,
    input  logic [PIX_WIDTH*DEPTH-1:0]     pix_in,
    input  logic                           pix_valid,
    input  logic                           pix_last,
    output logic                           pix_ready,
    output logic                           control,
    output logic [BIT_WIDTH*DEPTH-1:0]     wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]     data_arr,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     dbg_state
);

    // Handshake: a word transfers on a rising edge where valid && ready are both high.
    // Ready depends only on state, and valid is ignored while the matching ready is low.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_W = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam int WCW = $clog2(DEPTH + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    state_t                       r_state;
    logic [WCW-1:0]               r_wt_cnt;
    logic [DCW-1:0]               r_drain_cnt;
    logic                         r_control;
    logic [BIT_WIDTH*DEPTH-1:0]   r_wt_arr;
    logic                         r_done;

    logic                         w_wt_acc;
    logic                         w_pix_acc;

    assign w_wt_acc  = (r_state == S_LOAD_W) && wt_valid;
    assign w_pix_acc = (r_state == S_STREAM) && pix_valid;

    assign wt_ready  = (r_state == S_LOAD_W);
    assign pix_ready = (r_state == S_STREAM);
    assign busy      = (r_state != S_IDLE);
    assign control   = r_control;
    assign wt_arr    = r_wt_arr;
    assign done      = r_done;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wt_cnt    <= '0;
            r_drain_cnt <= '0;
            r_control   <= 1'b0;
            r_wt_arr    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_control <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_LOAD_W;
                        r_wt_cnt <= '0;
                    end
                end
                S_LOAD_W: begin
                    // The array shifts weights only on cycles where control is high.
                    if (w_wt_acc) begin
                        r_wt_arr  <= wt_in;
                        r_control <= 1'b1;
                        if (r_wt_cnt == WCW'(DEPTH - 1)) begin
                            r_state  <= S_STREAM;
                            r_wt_cnt <= '0;
                        end else begin
                            r_wt_cnt <= r_wt_cnt + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_pix_acc && pix_last) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
                        r_state     <= S_IDLE;
                        r_done      <= 1'b1;
                        r_wt_arr    <= '0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lane i is delayed by i+1 registers. Bubbles and drain cycles feed zeros into the lane.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
        logic [BIT_WIDTH-1:0] w_lane_in;
        logic [BIT_WIDTH-1:0] r_stage [gi+1];

        assign w_lane_in = w_pix_acc
            ? {{(BIT_WIDTH-PIX_WIDTH){1'b0}}, pix_in[gi*PIX_WIDTH +: PIX_WIDTH]}
            : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= gi; j++) begin
                    r_stage[j] <= '0;
                end
            end else begin
                r_stage[0] <= w_lane_in;
                for (int j = 1; j <= gi; j++) begin
                    r_stage[j] <= r_stage[j-1];
                end
            end
        end

        assign data_arr[gi*BIT_WIDTH +: BIT_WIDTH] = r_stage[gi];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed, table-driven bench for systolic_feeder. Each table row holds the inputs for one
// cycle and the outputs expected just after that cycle's rising edge.
module tb_systolic_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] wt_in = '0;
    logic        wt_valid = 1'b0;
    logic        wt_ready;
    logic [31:0] pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_last = 1'b0;
    logic        pix_ready;
    logic        control;
    logic [63:0] wt_arr;
    logic [63:0] data_arr;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    systolic_feeder #(
        .BIT_WIDTH(16), .DEPTH(4), .PIX_WIDTH(8), .DRAIN_CYCLES(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .wt_in(wt_in), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
        .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        wt_valid;
        logic [63:0] wt_in;
        logic        pix_valid;
        logic        pix_last;
        logic [31:0] pix_in;
        logic        e_control;
        logic [63:0] e_wt_arr;
        logic [63:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_wt_ready;
        logic        e_pix_ready;
        logic [1:0]  e_state;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] w_words [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".control"}, 64'(control), 64'd0);
        chk({tag, ".wt_arr"}, wt_arr, 64'd0);
        chk({tag, ".data_arr"}, data_arr, 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".wt_ready"}, 64'(wt_ready), 64'd0);
        chk({tag, ".pix_ready"}, 64'(pix_ready), 64'd0);
        chk({tag, ".state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic step(input vec_t r, input string tag);
        @(negedge clk);
        start     = r.start;
        wt_valid  = r.wt_valid;
        wt_in     = r.wt_in;
        pix_valid = r.pix_valid;
        pix_last  = r.pix_last;
        pix_in    = r.pix_in;
        @(posedge clk);
        #1;
        chk({tag, ".control"}, 64'(control), 64'(r.e_control));
        chk({tag, ".wt_arr"}, wt_arr, r.e_wt_arr);
        chk({tag, ".data_arr"}, data_arr, r.e_data);
        chk({tag, ".busy"}, 64'(busy), 64'(r.e_busy));
        chk({tag, ".done"}, 64'(done), 64'(r.e_done));
        chk({tag, ".wt_ready"}, 64'(wt_ready), 64'(r.e_wt_ready));
        chk({tag, ".pix_ready"}, 64'(pix_ready), 64'(r.e_pix_ready));
        chk({tag, ".state"}, 64'(dbg_state), 64'(r.e_state));
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", tag, i));
        tbl.delete();
    endtask

    function automatic vec_t blank();
        vec_t r;
        r = '{default: '0};
        return r;
    endfunction

    // A whole job: start, four weight columns (optional 2-cycle stall before the last),
    // nvec pixel vectors (optional bubble before vector 2), seven drain cycles, one idle cycle.
    task automatic build_job(input int nvec, input bit stall, input bit bubble);
        vec_t        r;
        logic [31:0] pushed[$];
        logic [31:0] pv;
        int          base;
        int          t;
        r = blank();
        r.start = 1'b1; r.e_busy = 1'b1; r.e_wt_ready = 1'b1; r.e_state = 2'd1;
        tbl.push_back(r);
        for (int w = 0; w < 4; w++) begin
            if (stall && w == 3) begin
                for (int s = 0; s < 2; s++) begin
                    r = blank();
                    r.wt_in = 64'hDEAD_BEEF_0BAD_F00D;
                    r.e_wt_arr = w_words[2]; r.e_busy = 1'b1; r.e_wt_ready = 1'b1; r.e_state = 2'd1;
                    tbl.push_back(r);
                end
            end
            r = blank();
            r.wt_valid = 1'b1; r.wt_in = w_words[w];
            r.e_control = 1'b1; r.e_wt_arr = w_words[w]; r.e_busy = 1'b1;
            r.e_wt_ready = (w < 3); r.e_pix_ready = (w == 3);
            r.e_state = (w < 3) ? 2'd1 : 2'd2;
            tbl.push_back(r);
        end
        base = tbl.size();
        for (int v = 0; v < nvec; v++) begin
            if (bubble && v == 2) begin
                r = blank();
                r.start = 1'b1; r.wt_valid = 1'b1; r.wt_in = 64'hFFFF_FFFF_FFFF_FFFF;
                r.pix_in = 32'hFFFF_FFFF;
                r.e_wt_arr = w_words[3]; r.e_busy = 1'b1; r.e_pix_ready = 1'b1; r.e_state = 2'd2;
                tbl.push_back(r);
                pushed.push_back(32'd0);
            end
            for (int i = 0; i < 4; i++) pv[8*i +: 8] = 8'(4*v + i);
            r = blank();
            r.wt_valid = 1'b1; r.wt_in = 64'h1234_5678_9ABC_DEF0;
            r.pix_valid = 1'b1; r.pix_in = pv; r.pix_last = (v == nvec - 1);
            r.e_wt_arr = w_words[3]; r.e_busy = 1'b1;
            r.e_pix_ready = (v != nvec - 1);
            r.e_state = (v == nvec - 1) ? 2'd3 : 2'd2;
            tbl.push_back(r);
            pushed.push_back(pv);
        end
        for (int d = 1; d <= 7; d++) begin
            r = blank();
            r.pix_valid = 1'b1; r.pix_last = 1'b1; r.pix_in = 32'hA5A5_A5A5;
            r.start = (d < 7);
            if (d < 7) begin
                r.e_wt_arr = w_words[3]; r.e_busy = 1'b1; r.e_state = 2'd3;
            end else begin
                r.e_done = 1'b1;
            end
            tbl.push_back(r);
            pushed.push_back(32'd0);
        end
        tbl.push_back(blank());
        // Lane i after edge t carries what entered the feeder i edges before lane 0 would show it.
        for (t = 0; t < pushed.size(); t++) begin
            r = tbl[base + t];
            r.e_data = '0;
            for (int i = 0; i < 4; i++) begin
                if (t - i >= 0) begin
                    pv = pushed[t - i];
                    r.e_data[16*i +: 16] = {8'h00, pv[8*i +: 8]};
                end
            end
            tbl[base + t] = r;
        end
    endtask

    task automatic mid_reset(input int rows, input string tag);
        build_job(4, 1'b0, 1'b0);
        for (int i = 0; i < rows; i++) step(tbl[i], $sformatf("%s_pre[%0d]", tag, i));
        tbl.delete();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_async"});
        @(negedge clk);
        start = 1'b0; wt_valid = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero({tag, "_post"});
        build_job(4, 1'b0, 1'b0);
        run_table({tag, "_rerun"});
    endtask

    initial begin
        w_words[0] = 64'hFFFF_0000_0000_0000;
        w_words[1] = 64'h0000_FFFF_0000_0000;
        w_words[2] = 64'h0000_0000_FFFF_0000;
        w_words[3] = 64'h0000_0000_0000_0001;

        #1;
        check_zero("reset_t0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) tbl.push_back(blank());
        run_table("idle");

        build_job(4, 1'b0, 1'b0);
        run_table("skew");

        build_job(4, 1'b1, 1'b0);
        run_table("wstall");

        build_job(4, 1'b0, 1'b1);
        run_table("bubble");

        build_job(1, 1'b0, 1'b0);
        run_table("single");

        mid_reset(3, "rst_load");
        mid_reset(7, "rst_stream");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
